confreg_resp: RTL and testbench
===============================

Name: confreg_resp

Overview:
- Memory-mapped configuration/peripheral responder on the data-SRAM side of the core.
- Sits at the slave end of the data_sram_* interface that the CPU drives, and answers it with synchronous-SRAM timing (one-cycle read latency, byte-enabled writes).
- Holds scratch registers, LED output, synchronised switch input, a free-running timer with compare/interrupt, and a read-only simulation flag.

Parameters:
- BASE_ADDR, 32'hBFAF_0000, window base; decoded on addr[31:16].
- SIMU_FLAG, 32'hFFFF_FFFF, value returned by the SIMU register.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- data_sram_en  in  1  access request this cycle.
- data_sram_we  in  4  byte write enables; 0 means read.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data, registered.
- switch  in  8  asynchronous board switches.
- led  out  16  LED register.
- timer_irq  out  1  timer interrupt, level.

Behaviour:
- Reset: data_sram_rdata=0, led=0, timer_irq=0. All internal registers and both switch sync flops are 0.
- Hit condition: data_sram_en && addr[31:16]==BASE_ADDR[31:16]. The register offset is addr[7:0] with addr[1:0] ignored. addr[15:8] must be 0 for a hit; otherwise the access is treated as unmapped.
- Register map (offset, access, contents):
  - 0x00 SCRATCH0, RW, 32 bits.
  - 0x04 SCRATCH1, RW, 32 bits.
  - 0x10 LED, RW, [15:0]; bits [31:16] read 0 and writes to them are dropped.
  - 0x14 SWITCH, RO, [7:0] = 2-flop synchronised switch; upper bits read 0.
  - 0x20 TIMER, RW, 32-bit counter.
  - 0x24 TIMER_CMP, RW, 32 bits.
  - 0x28 TIMER_CTRL:
    - bit0 EN, RW.
    - bit1 IRQ_EN, RW.
    - bit2 STATUS, write-1-to-clear.
    - Other bits read 0.
  - 0x30 SIMU, RO, returns SIMU_FLAG.
- Write (hit && we!=0):
  - Each byte lane i with we[i]=1 takes wdata[8i+7:8i]. Other lanes keep their old value.
  - The register updates at the clock edge ending the request cycle.
- Read (hit && we==0): data_sram_rdata is updated at that same edge with the register value as it was before that edge. The value is valid the cycle after the request, with exactly 1-cycle latency.
- Read-after-write: a read issued the cycle after a write returns the new value.
- Unmapped or out-of-window access:
  - Read: data_sram_rdata becomes 0.
  - Write: no state change.
- No read this cycle (en=0, or any write): data_sram_rdata holds its previous value.
- Timer:
  - When EN=1, TIMER increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0. When EN=0 it holds.
  - A write to TIMER has priority over the increment: the next value is the byte-merge of wdata into the current (not incremented) value. Incrementing resumes the following cycle.
  - Match: when EN=1 && TIMER==TIMER_CMP, STATUS is set at the next edge.
  - If a write-1-to-STATUS occurs in the same cycle as a match, the set wins and STATUS stays 1.
  - timer_irq = STATUS && IRQ_EN. It is registered-combinational from flops and has no extra delay.
- The 32-bit compare and increment carry no width extension; overflow simply wraps.
- Asynchronous reset mid-transaction: all state returns to reset values immediately. The pending read returns nothing and data_sram_rdata=0.

Test Plan:
- Reset, then read SIMU (en=1, we=0, addr=BFAF_0030) -> rdata=FFFF_FFFF on the next cycle. Read SCRATCH0 -> 0.
- Write SCRATCH1 with we=4'b0101, wdata=AABB_CCDD over old 1122_3344 -> read returns 11BB_33DD. Write LED with we=F, wdata=DEAD_BEEF -> led=BEEF and LED reads 0000_BEEF.
- switch=8'h5A applied asynchronously -> SWITCH reads 0000_005A no earlier than 2 cycles later. A read of unmapped offset 0x3C, or of address BFAE_0000, -> rdata=0; a write there changes nothing.
- Write TIMER=FFFF_FFFE, then TIMER_CTRL=1 -> successive reads show wrap to 0000_0000 and continued counting. Writing TIMER while enabled -> the next read equals the written value + elapsed cycles.
- Set TIMER_CMP=10, TIMER=0, CTRL=3 -> timer_irq rises once TIMER reaches 10 (STATUS set at the following edge). Write CTRL=7 with no match -> irq falls. Write-1 to STATUS in the exact match cycle -> STATUS stays 1.
- Assert reset in the cycle right after a read request -> rdata=0, led=0, irq=0, timer=0, with no stale data after release.

Source files
------------

// File: rtl/confreg_resp.sv
// Memory-mapped configuration responder on the data SRAM port: scratch regs, LEDs,
// synchronised switches, a compare/interrupt timer and a read-only simulation flag.
module confreg_resp #(
  parameter logic [31:0] BASE_ADDR = 32'hBFAF_0000,
  parameter logic [31:0] SIMU_FLAG = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_irq
);

  // Word offsets (addr[7:2]) of the register map.
  localparam logic [5:0] OFF_SCR0  = 6'h00;
  localparam logic [5:0] OFF_SCR1  = 6'h01;
  localparam logic [5:0] OFF_LED   = 6'h04;
  localparam logic [5:0] OFF_SW    = 6'h05;
  localparam logic [5:0] OFF_TIMER = 6'h08;
  localparam logic [5:0] OFF_CMP   = 6'h09;
  localparam logic [5:0] OFF_CTRL  = 6'h0A;
  localparam logic [5:0] OFF_SIMU  = 6'h0C;

  // Request/response: a request is any cycle with data_sram_en=1 (no back-pressure).
  // Writes commit at the closing edge; reads load data_sram_rdata at that same edge
  // with the pre-edge register value, so data is valid exactly one cycle later.

  logic [31:0] scratch0, scratch1, timer, timer_cmp;
  logic [15:0] led_q;
  logic [7:0]  sw_meta, sw_sync;
  logic        ctrl_en, ctrl_irq_en, status;

  logic        hit, rd, wr, match, status_clr;
  logic [5:0]  off;
  logic [31:0] rd_val;
  logic [31:0] led_merged, scr0_merged, scr1_merged, timer_merged, cmp_merged;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  assign unused_addr_bits = &{1'b0, data_sram_addr[1:0]};

  assign hit = data_sram_en &&
               (data_sram_addr[31:16] == BASE_ADDR[31:16]) &&
               (data_sram_addr[15:8] == 8'h00);
  assign off = data_sram_addr[7:2];
  assign rd  = hit && (data_sram_we == 4'b0000);
  assign wr  = hit && (data_sram_we != 4'b0000);

  assign led_merged   = merge({16'h0000, led_q}, data_sram_wdata, data_sram_we);
  assign scr0_merged  = merge(scratch0, data_sram_wdata, data_sram_we);
  assign scr1_merged  = merge(scratch1, data_sram_wdata, data_sram_we);
  assign timer_merged = merge(timer, data_sram_wdata, data_sram_we);
  assign cmp_merged   = merge(timer_cmp, data_sram_wdata, data_sram_we);

  assign match      = ctrl_en && (timer == timer_cmp);
  assign status_clr = wr && (off == OFF_CTRL) && data_sram_we[0] && data_sram_wdata[2];

  always_comb begin
    rd_val = 32'h0000_0000;
    case (off)
      OFF_SCR0:  rd_val = scratch0;
      OFF_SCR1:  rd_val = scratch1;
      OFF_LED:   rd_val = {16'h0000, led_q};
      OFF_SW:    rd_val = {24'h000000, sw_sync};
      OFF_TIMER: rd_val = timer;
      OFF_CMP:   rd_val = timer_cmp;
      OFF_CTRL:  rd_val = {29'h0, status, ctrl_irq_en, ctrl_en};
      OFF_SIMU:  rd_val = SIMU_FLAG;
      default:   rd_val = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch0        <= '0;
      scratch1        <= '0;
      led_q           <= '0;
      sw_meta         <= '0;
      sw_sync         <= '0;
      timer           <= '0;
      timer_cmp       <= '0;
      ctrl_en         <= 1'b0;
      ctrl_irq_en     <= 1'b0;
      status          <= 1'b0;
      data_sram_rdata <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;

      if (rd) data_sram_rdata <= rd_val;
      else if (data_sram_en && !hit && data_sram_we == 4'b0000) data_sram_rdata <= '0;

      if (wr && off == OFF_SCR0) scratch0  <= scr0_merged;
      if (wr && off == OFF_SCR1) scratch1  <= scr1_merged;
      if (wr && off == OFF_LED)  led_q     <= led_merged[15:0];
      if (wr && off == OFF_CMP)  timer_cmp <= cmp_merged;

      // A software write to TIMER overrides the increment for that cycle.
      if (wr && off == OFF_TIMER) timer <= timer_merged;
      else if (ctrl_en)           timer <= timer + 32'd1;

      if (wr && off == OFF_CTRL && data_sram_we[0]) begin
        ctrl_en     <= data_sram_wdata[0];
        ctrl_irq_en <= data_sram_wdata[1];
      end

      // A match in the same cycle as a write-1-to-clear keeps STATUS set.
      if (match)           status <= 1'b1;
      else if (status_clr) status <= 1'b0;
    end
  end

  assign led       = led_q;
  assign timer_irq = status && ctrl_irq_en;

endmodule

// File: tb/tb_confreg_resp.sv
// Bench for confreg_resp: vector table through a read-data scoreboard, then
// hand-written sequences for switch sync, timer wrap/compare/irq and mid-run reset.
module tb_confreg_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_we = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch = 8'h00;
  logic [15:0] led;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] B = 32'hBFAF_0000;

  confreg_resp dut (
    .clk(clk),
    .reset(reset),
    .data_sram_en(data_sram_en),
    .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .switch(switch),
    .led(led),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One bus cycle; when chk is set the expected rdata after the edge is queued.
  task automatic bus_cycle(input logic en, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic chk,
                           input logic [31:0] exp, input string name);
    logic [31:0] e;
    string n;
    data_sram_en = en;
    data_sram_we = we;
    data_sram_addr = addr;
    data_sram_wdata = wdata;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, data_sram_rdata, e);
    end
  endtask

  task automatic do_read(input logic [7:0] off, input logic [31:0] exp, input string name);
    bus_cycle(1'b1, 4'h0, B | {24'h0, off}, 32'h0, 1'b1, exp, name);
  endtask

  task automatic do_write(input logic [7:0] off, input logic [3:0] we, input logic [31:0] d);
    bus_cycle(1'b1, we, B | {24'h0, off}, d, 1'b0, 32'h0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  function automatic void add(input logic en, input logic [3:0] we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic chk,
                              input logic [31:0] exp, input string name);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.chk = chk; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    add(1, 4'h0, B | 32'h30, 32'h0,         1, 32'hFFFF_FFFF, "simu");
    add(1, 4'h0, B | 32'h00, 32'h0,         1, 32'h0000_0000, "scratch0_rst");
    add(1, 4'hF, B | 32'h04, 32'h1122_3344, 1, 32'h0000_0000, "hold_on_write");
    add(1, 4'h5, B | 32'h04, 32'hAABB_CCDD, 0, 32'h0,         "");
    add(1, 4'h0, B | 32'h04, 32'h0,         1, 32'h11BB_33DD, "scratch1_merge");
    add(0, 4'h0, 32'h0,      32'h0,         1, 32'h11BB_33DD, "hold_on_idle");
    add(1, 4'hF, B | 32'h10, 32'hDEAD_BEEF, 0, 32'h0,         "");
    add(1, 4'h0, B | 32'h10, 32'h0,         1, 32'h0000_BEEF, "led_read");
    add(1, 4'hC, B | 32'h10, 32'h1234_5678, 0, 32'h0,         "");
    add(1, 4'h0, B | 32'h10, 32'h0,         1, 32'h0000_BEEF, "led_upper_drop");
    add(1, 4'h0, B | 32'h3C, 32'h0,         1, 32'h0000_0000, "unmapped_off");
    add(1, 4'h0, B | 32'h30, 32'h0,         1, 32'hFFFF_FFFF, "simu_again");
    add(1, 4'h0, 32'hBFAE_0000, 32'h0,      1, 32'h0000_0000, "out_window");
    add(1, 4'hF, 32'hBFAE_0000, 32'h1234_5678, 0, 32'h0,      "");
    add(1, 4'hF, 32'hBFAF_0100, 32'h8765_4321, 0, 32'h0,      "");
    add(1, 4'hF, B | 32'h3C, 32'hCAFE_F00D, 0, 32'h0,         "");
    add(1, 4'h0, B | 32'h00, 32'h0,         1, 32'h0000_0000, "scratch0_untouched");
    add(1, 4'hF, B | 32'h30, 32'h0,         0, 32'h0,         "");
    add(1, 4'h0, B | 32'h30, 32'h0,         1, 32'hFFFF_FFFF, "simu_ro");
    add(1, 4'hF, B | 32'h00, 32'h0000_FFFF, 0, 32'h0,         "");
    add(1, 4'h8, B | 32'h00, 32'hAB00_0000, 0, 32'h0,         "");
    add(1, 4'h0, B | 32'h00, 32'h0,         1, 32'hAB00_FFFF, "scratch0_lane3");
    add(1, 4'h0, 32'hBFAF_0100, 32'h0,      1, 32'h0000_0000, "alias_hi_bits");
    add(1, 4'hF, B | 32'h28, 32'hFFFF_FFF8, 0, 32'h0,         "");
    add(1, 4'h0, B | 32'h28, 32'h0,         1, 32'h0000_0000, "ctrl_upper_zero");

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      bus_cycle(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].chk, vecs[i].exp, vecs[i].name);
    check("led_port", {16'h0, led}, 32'h0000_BEEF);

    // Switch passes through two flops before it is visible.
    switch = 8'h5A;
    do_read(8'h14, 32'h0000_0000, "switch_sync1");
    do_read(8'h14, 32'h0000_0000, "switch_sync2");
    do_read(8'h14, 32'h0000_005A, "switch_sync3");

    // Timer wrap
    do_write(8'h20, 4'hF, 32'hFFFF_FFFE);
    do_write(8'h28, 4'hF, 32'h0000_0001);
    do_read(8'h20, 32'hFFFF_FFFE, "timer_wrap0");
    do_read(8'h20, 32'hFFFF_FFFF, "timer_wrap1");
    do_read(8'h20, 32'h0000_0000, "timer_wrap2");
    do_read(8'h20, 32'h0000_0001, "timer_wrap3");

    // Write while counting
    do_write(8'h20, 4'hF, 32'h0000_0100);
    idle(2);
    do_read(8'h20, 32'h0000_0102, "timer_wr_running");

    // Compare / interrupt
    do_write(8'h28, 4'hF, 32'h0000_0000);
    do_write(8'h28, 4'hF, 32'h0000_0004);
    check("irq_cleared", {31'h0, timer_irq}, 32'h0);
    do_write(8'h24, 4'hF, 32'd10);
    do_write(8'h20, 4'hF, 32'd0);
    do_write(8'h28, 4'hF, 32'h0000_0003);
    idle(10);
    check("irq_before_match", {31'h0, timer_irq}, 32'h0);
    idle(1);
    check("irq_rise", {31'h0, timer_irq}, 32'h1);
    idle(2);
    do_write(8'h28, 4'hF, 32'h0000_0007);
    check("irq_fall", {31'h0, timer_irq}, 32'h0);
    do_read(8'h28, 32'h0000_0003, "ctrl_after_clear");

    // Write-1-to-clear in the match cycle loses to the set
    do_write(8'h28, 4'hF, 32'h0000_0000);
    do_write(8'h20, 4'hF, 32'd20);
    do_write(8'h24, 4'hF, 32'd21);
    do_write(8'h28, 4'hF, 32'h0000_0003);
    idle(1);
    do_write(8'h28, 4'hF, 32'h0000_0007);
    check("w1c_vs_match", {31'h0, timer_irq}, 32'h1);
    do_read(8'h28, 32'h0000_0007, "ctrl_status_set");

    // Reset right after a read has returned data
    do_read(8'h04, 32'h11BB_33DD, "pre_reset_read");
    reset = 1'b1;
    #2;
    check("mid_rst_rdata", data_sram_rdata, 32'h0);
    check("mid_rst_led", {16'h0, led}, 32'h0);
    check("mid_rst_irq", {31'h0, timer_irq}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("no_stale_rdata", data_sram_rdata, 32'h0);
    do_read(8'h20, 32'h0000_0000, "timer_after_rst");
    do_read(8'h04, 32'h0000_0000, "scratch1_after_rst");
    do_read(8'h10, 32'h0000_0000, "led_after_rst");

    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
